// File: rtl/main_control.sv
// ID-stage main decoder for the RV32I pipeline: opcode -> datapath controls,
// branch resolution, and a sticky flag recording any unsupported opcode.
module main_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero_flag,
  output logic [1:0] alu_op,
  output logic       branch,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic       reg_write,
  output logic       pc_src,
  output logic       illegal_opcode,
  output logic       illegal_seen
);

  typedef enum logic [6:0] {
    OP_R_TYPE = 7'b0110011,
    OP_I_ALU  = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_ITYPE  = 2'b11
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    branch;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    reg_write;
    logic    illegal;
  } ctrl_t;

  ctrl_t ctrl;

  always_comb begin
    // NOTE: the all-zero default comes first so every path assigns every
    // field; this avoids latches and makes unknown opcodes side-effect free.
    ctrl = '0;
    unique case (opcode)
      OP_R_TYPE: begin
        ctrl.alu_op    = ALU_RTYPE;
        ctrl.reg_write = 1'b1;
      end
      OP_I_ALU: begin
        ctrl.alu_op    = ALU_ITYPE;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_LOAD: begin
        ctrl.alu_op     = ALU_ADD;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OP_STORE: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.alu_op = ALU_BRANCH;
        ctrl.branch = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

  assign alu_op         = ctrl.alu_op;
  assign branch         = ctrl.branch;
  assign mem_read       = ctrl.mem_read;
  assign mem_write      = ctrl.mem_write;
  assign mem_to_reg     = ctrl.mem_to_reg;
  assign alu_src        = ctrl.alu_src;
  assign reg_write      = ctrl.reg_write;
  assign pc_src         = ctrl.branch & zero_flag;
  assign illegal_opcode = ctrl.illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_seen <= 1'b0;
    end else begin
      // NOTE: non-blocking so the flag updates with the edge, not mid-evaluation.
      illegal_seen <= illegal_seen | ctrl.illegal;
    end
  end

endmodule

// File: tb/tb_main_control.sv
// Directed self-checking bench for main_control: decode table, branch
// resolution, sticky illegal flag and asynchronous reset behaviour.
module tb_main_control;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero_flag;
  logic [1:0] alu_op;
  logic       branch, mem_read, mem_write, mem_to_reg, alu_src, reg_write;
  logic       pc_src, illegal_opcode, illegal_seen;

  int total = 0;
  int bad   = 0;

  // {alu_op, branch, mem_read, mem_write, mem_to_reg, alu_src, reg_write, pc_src, illegal_opcode}
  logic [9:0] ctl;
  assign ctl = {alu_op, branch, mem_read, mem_write, mem_to_reg, alu_src,
                reg_write, pc_src, illegal_opcode};

  localparam logic [9:0] EXP_R      = 10'b10_0_0_0_0_0_1_0_0;
  localparam logic [9:0] EXP_I      = 10'b11_0_0_0_0_1_1_0_0;
  localparam logic [9:0] EXP_LOAD   = 10'b00_0_1_0_1_1_1_0_0;
  localparam logic [9:0] EXP_STORE  = 10'b00_0_0_1_0_1_0_0_0;
  localparam logic [9:0] EXP_BR_NT  = 10'b01_1_0_0_0_0_0_0_0;
  localparam logic [9:0] EXP_BR_T   = 10'b01_1_0_0_0_0_0_1_0;
  localparam logic [9:0] EXP_ILL    = 10'b00_0_0_0_0_0_0_0_1;

  main_control dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .opcode         (opcode),
    .zero_flag      (zero_flag),
    .alu_op         (alu_op),
    .branch         (branch),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_to_reg     (mem_to_reg),
    .alu_src        (alu_src),
    .reg_write      (reg_write),
    .pc_src         (pc_src),
    .illegal_opcode (illegal_opcode),
    .illegal_seen   (illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; opcode = 7'b1111111; zero_flag = 1'b0;
    @(posedge clk); #1;
    total++;
    if (illegal_seen !== 1'b0) begin
      bad++; $display("FAIL reset_seen: got %b want 0", illegal_seen);
    end
    total++;
    if (ctl !== EXP_ILL) begin
      bad++; $display("FAIL reset_decode: got %b want %b", ctl, EXP_ILL);
    end
    opcode = 7'b0110011;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (illegal_seen !== 1'b0) begin
      bad++; $display("FAIL post_reset_seen: got %b want 0", illegal_seen);
    end
  endtask

  task automatic test_branch();
    opcode = 7'b1100011; zero_flag = 1'b0; #1;
    total++;
    if (ctl !== EXP_BR_NT) begin
      bad++; $display("FAIL branch_not_taken: got %b want %b", ctl, EXP_BR_NT);
    end
    zero_flag = 1'b1; #1;
    total++;
    if (ctl !== EXP_BR_T) begin
      bad++; $display("FAIL branch_taken: got %b want %b", ctl, EXP_BR_T);
    end
    opcode = 7'b0110011; #1;
    total++;
    if (pc_src !== 1'b0) begin
      bad++; $display("FAIL rtype_pc_src_zero1: got %b want 0", pc_src);
    end
  endtask

  task automatic test_load_store();
    zero_flag = 1'b0;
    opcode = 7'b0000011; #1;
    total++;
    if (ctl !== EXP_LOAD) begin
      bad++; $display("FAIL load: got %b want %b", ctl, EXP_LOAD);
    end
    opcode = 7'b0100011; #1;
    total++;
    if (ctl !== EXP_STORE) begin
      bad++; $display("FAIL store: got %b want %b", ctl, EXP_STORE);
    end
  endtask

  task automatic test_alu();
    opcode = 7'b0110011; #1;
    total++;
    if (ctl !== EXP_R) begin
      bad++; $display("FAIL rtype: got %b want %b", ctl, EXP_R);
    end
    opcode = 7'b0010011; #1;
    total++;
    if (ctl !== EXP_I) begin
      bad++; $display("FAIL itype: got %b want %b", ctl, EXP_I);
    end
  endtask

  // Non-branch opcodes never redirect the PC, even with zero_flag high.
  task automatic test_pc_src_nonbranch();
    logic [6:0] ops [5];
    logic [9:0] exp [5];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0000000};
    exp = '{EXP_R, EXP_I, EXP_LOAD, EXP_STORE, EXP_ILL};
    zero_flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      opcode = ops[i]; #1;
      total++;
      if (ctl !== exp[i]) begin
        bad++; $display("FAIL nonbranch_zero1 op=%b: got %b want %b", ops[i], ctl, exp[i]);
      end
    end
    opcode = 7'b0110011; zero_flag = 1'b0; #1;
  endtask

  task automatic test_illegal_sticky();
    @(negedge clk);
    total++;
    if (illegal_seen !== 1'b0) begin
      bad++; $display("FAIL sticky_pre: got %b want 0", illegal_seen);
    end
    opcode = 7'b1111111; #1;
    total++;
    if (ctl !== EXP_ILL) begin
      bad++; $display("FAIL illegal_decode: got %b want %b", ctl, EXP_ILL);
    end
    total++;
    if (illegal_seen !== 1'b0) begin
      bad++; $display("FAIL sticky_before_edge: got %b want 0", illegal_seen);
    end
    @(posedge clk); #1;
    total++;
    if (illegal_seen !== 1'b1) begin
      bad++; $display("FAIL sticky_set: got %b want 1", illegal_seen);
    end
    opcode = 7'b0000011;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (illegal_seen !== 1'b1) begin
      bad++; $display("FAIL sticky_hold: got %b want 1", illegal_seen);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    total++;
    if (illegal_seen !== 1'b0) begin
      bad++; $display("FAIL async_clear: got %b want 0", illegal_seen);
    end
    total++;
    if (ctl !== EXP_LOAD) begin
      bad++; $display("FAIL decode_in_reset: got %b want %b", ctl, EXP_LOAD);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (illegal_seen !== 1'b0) begin
      bad++; $display("FAIL legal_after_release: got %b want 0", illegal_seen);
    end
    @(negedge clk);
    opcode = 7'b0000000;
    @(posedge clk); #1;
    total++;
    if (illegal_seen !== 1'b1) begin
      bad++; $display("FAIL zero_opcode_sets_sticky: got %b want 1", illegal_seen);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_load_store();
    test_alu();
    test_pc_src_nonbranch();
    test_illegal_sticky();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
